// File: rtl/pool_window_buffer_if.sv
// Pixel stream in, 2x2 window words out.
// master drives px_in/px_valid; slave drives win1..win4/win_en/frame_done.
interface pool_window_buffer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] px_in;
  logic              px_valid;
  logic [DATA_W-1:0] win1;
  logic [DATA_W-1:0] win2;
  logic [DATA_W-1:0] win3;
  logic [DATA_W-1:0] win4;
  logic              win_en;
  logic              frame_done;

  modport master (
    output px_in, px_valid,
    input  win1, win2, win3, win4,
    input  win_en, frame_done
  );

  modport slave (
    input  px_in, px_valid,
    output win1, win2, win3, win4,
    output win_en, frame_done
  );
endinterface

// File: rtl/pool_window_buffer.sv
// Row buffer forming stride-2 2x2 windows for max pooling.
// Ports: clk, rst (sync, active high), io (slave: pixels in, windows out).
module pool_window_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input logic clk,
  input logic rst,
  pool_window_buffer_if.slave io
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {FILL, PAIR} phase_e;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] prev_px;
  logic [DATA_W-1:0] line_buf [IMG_W];
  logic [DATA_W-1:0] w1_q, w2_q, w3_q, w4_q;
  logic              en_q, fd_q;

  phase_e        phase;
  logic          col_last;
  logic          row_last;
  logic          emit;
  logic [CW-1:0] col_l;

  assign phase    = row[0] ? PAIR : FILL;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // odd col on odd row is always a bottom-right pixel;
  // a trailing odd column/row has even index, so never emits
  assign emit     = io.px_valid && (phase == PAIR) && col[0];
  assign col_l    = col - CW'(1);

  // no reset: contents are don't-care until rewritten
  always_ff @(posedge clk) begin
    if (!rst && io.px_valid && phase == FILL)
      line_buf[col] <= io.px_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      prev_px <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      w4_q    <= '0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      en_q <= 1'b0;
      fd_q <= 1'b0;
      if (io.px_valid) begin
        prev_px <= io.px_in;
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row  <= '0;
            fd_q <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
        if (emit) begin
          w1_q <= line_buf[col_l];
          w2_q <= line_buf[col];
          w3_q <= prev_px;
          w4_q <= io.px_in;
          en_q <= 1'b1;
        end
      end
    end
  end

  assign io.win1       = w1_q;
  assign io.win2       = w2_q;
  assign io.win3       = w3_q;
  assign io.win4       = w4_q;
  assign io.win_en     = en_q;
  assign io.frame_done = fd_q;
endmodule
